// File: rtl/ahb3lite_simple_master.sv
// ahb3lite_simple_master
// Single-outstanding AHB3-Lite master: converts one command into one SINGLE
// NONSEQ transfer and reports the completion with a one-cycle rsp_valid pulse.
// FSM: IDLE -> ADDR (address phase) -> DATA (data phase) -> IDLE.
// Optional feature: define AHB3LITE_MASTER_ALIGN_CHECK_EN to reject misaligned
// or oversized commands locally with an error response and no bus transfer.
module ahb3lite_simple_master #(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        CLK,
    input  logic        RESET,
    // command side
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    // response side
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    // AHB3-Lite master port
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [31:0] HRDATA
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    logic [1:0] state;
    logic       accept;
    logic       cmd_bad;

    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;

    // Ready only when idle and not held in reset.
    assign cmd_ready = (state == ST_IDLE) && !RESET;
    assign accept    = cmd_valid && cmd_ready;

    // NONSEQ only during the address phase; the data phase is always IDLE.
    assign HTRANS = (state == ST_ADDR) ? TRANS_NONSEQ : TRANS_IDLE;

`ifdef AHB3LITE_MASTER_ALIGN_CHECK_EN
    // Flag sizes above word and addresses not aligned to the transfer size.
    always_comb begin
        cmd_bad = 1'b0;
        case (cmd_size)
            3'd0:    cmd_bad = 1'b0;
            3'd1:    cmd_bad = cmd_addr[0];
            3'd2:    cmd_bad = (cmd_addr[1:0] != 2'b00);
            default: cmd_bad = 1'b1;
        endcase
    end
`else
    // Every command is forwarded to the bus unchanged.
    assign cmd_bad = 1'b0;
`endif

    // Transfer sequencing, address/data latching and response generation.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_IDLE;
            HADDR     <= '0;
            HWRITE    <= 1'b0;
            HSIZE     <= '0;
            HWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (cmd_bad) begin
                            // Rejected locally: bus signals keep their old values.
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            HADDR  <= cmd_addr;
                            HWRITE <= cmd_write;
                            HSIZE  <= cmd_size;
                            HWDATA <= cmd_wdata;
                            state  <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (HREADY) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // HRESP=1 with HREADY=0 is the first ERROR cycle and just waits.
                    if (HREADY) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= HRESP;
                        rsp_rdata <= (HRESP || HWRITE) ? '0 : HRDATA;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb3lite_simple_master.sv
// Directed self-checking bench for ahb3lite_simple_master.
// Inputs are driven 1 time unit after each rising edge; outputs are checked
// 1 time unit after that, well away from the next edge.
module tb_ahb3lite_simple_master;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;

    int checks = 0;
    int errors = 0;

    ahb3lite_simple_master #(.HPROT_VAL(4'b0011)) dut (
        .CLK(CLK), .RESET(RESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_size  = sz;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", cmd_ready); end
        checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL rst_htrans: got %b expected 00", HTRANS); end
        checks++; if (HADDR !== 32'h0) begin errors++; $display("FAIL rst_haddr: got %h expected 0", HADDR); end
        checks++; if (HWDATA !== 32'h0) begin errors++; $display("FAIL rst_hwdata: got %h expected 0", HWDATA); end
        checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp: got v=%b e=%b d=%h expected 0/0/0", rsp_valid, rsp_err, rsp_rdata); end
        checks++; if (HBURST !== 3'b000 || HPROT !== 4'b0011 || HMASTLOCK !== 1'b0) begin errors++; $display("FAIL rst_ties: got burst=%b prot=%b lock=%b expected 000/0011/0", HBURST, HPROT, HMASTLOCK); end
        RESET = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_zero_wait_read();
        tick();
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'hDEADBEEF;
        issue(1'b0, 3'd2, 32'h0000_1000, 32'h0);
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rd_accept_ready: got %b expected 1", cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        #1;
        checks++; if (HTRANS !== 2'b10) begin errors++; $display("FAIL rd_nonseq: got %b expected 10", HTRANS); end
        checks++; if (HADDR !== 32'h1000 || HWRITE !== 1'b0 || HSIZE !== 3'd2) begin errors++; $display("FAIL rd_addr_phase: got a=%h w=%b s=%0d expected 1000/0/2", HADDR, HWRITE, HSIZE); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rd_busy_ready: got %b expected 0", cmd_ready); end
        tick();
        #1;
        checks++; if (HTRANS !== 2'b00 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_data_phase: got trans=%b v=%b expected 00/0", HTRANS, rsp_valid); end
        tick();
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rsp: got v=%b e=%b d=%h expected 1/0/deadbeef", rsp_valid, rsp_err, rsp_rdata); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rd_done_ready: got %b expected 1", cmd_ready); end
        checks++; if (HADDR !== 32'h1000) begin errors++; $display("FAIL rd_haddr_hold: got %h expected 1000", HADDR); end
        tick();
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_rsp_pulse: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_write_wait_states();
        tick();
        HREADY = 1'b1; HRESP = 1'b0;
        issue(1'b1, 3'd2, 32'h0000_0020, 32'hCAFEF00D);
        tick();
        cmd_valid = 1'b0;
        #1;
        checks++; if (HTRANS !== 2'b10 || HWRITE !== 1'b1 || HADDR !== 32'h20) begin errors++; $display("FAIL wr_nonseq: got trans=%b w=%b a=%h expected 10/1/20", HTRANS, HWRITE, HADDR); end
        for (int unsigned i = 0; i < 4; i++) begin
            tick();
            HREADY = (i == 3);
            #1;
            checks++; if (HWDATA !== 32'hCAFEF00D || HTRANS !== 2'b00 || rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_data_cycle%0d: got d=%h trans=%b v=%b expected cafef00d/00/0", i, HWDATA, HTRANS, rsp_valid); end
        end
        tick();
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_rsp: got v=%b e=%b d=%h expected 1/0/0", rsp_valid, rsp_err, rsp_rdata); end
        tick();
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rsp_pulse: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_error_response();
        tick();
        HREADY = 1'b0; HRESP = 1'b0; HRDATA = 32'h12345678;
        issue(1'b0, 3'd2, 32'h0000_0040, 32'h0);
        tick();
        cmd_valid = 1'b0;
        #1;
        checks++; if (HTRANS !== 2'b10) begin errors++; $display("FAIL err_addr_wait0: got %b expected 10", HTRANS); end
        tick();
        HREADY = 1'b1;
        #1;
        checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h40) begin errors++; $display("FAIL err_addr_hold: got trans=%b a=%h expected 10/40", HTRANS, HADDR); end
        tick();
        HREADY = 1'b0; HRESP = 1'b1;
        #1;
        checks++; if (HTRANS !== 2'b00 || rsp_valid !== 1'b0) begin errors++; $display("FAIL err_first_cycle: got trans=%b v=%b expected 00/0", HTRANS, rsp_valid); end
        tick();
        HREADY = 1'b1; HRESP = 1'b1;
        #1;
        checks++; if (HTRANS !== 2'b00 || rsp_valid !== 1'b0) begin errors++; $display("FAIL err_second_cycle: got trans=%b v=%b expected 00/0", HTRANS, rsp_valid); end
        tick();
        HRESP = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL err_rsp: got v=%b e=%b d=%h expected 1/1/0", rsp_valid, rsp_err, rsp_rdata); end
        tick();
        #1;
        checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL err_rsp_pulse: got v=%b e=%b expected 0/0", rsp_valid, rsp_err); end
    endtask

    task automatic test_reset_mid_transfer();
        tick();
        HREADY = 1'b1; HRESP = 1'b0;
        issue(1'b1, 3'd2, 32'h0000_0080, 32'h11112222);
        tick();
        cmd_valid = 1'b0;
        tick();
        HREADY = 1'b0;
        #1;
        checks++; if (HTRANS !== 2'b00 || HWDATA !== 32'h11112222) begin errors++; $display("FAIL rm_data_phase: got trans=%b d=%h expected 00/11112222", HTRANS, HWDATA); end
        tick();
        RESET = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rm_ready_in_reset: got %b expected 0", cmd_ready); end
        tick();
        RESET = 1'b0; HREADY = 1'b1;
        #1;
        checks++; if (HTRANS !== 2'b00 || rsp_valid !== 1'b0 || HADDR !== 32'h0 || HWDATA !== 32'h0) begin errors++; $display("FAIL rm_after_reset: got trans=%b v=%b a=%h d=%h expected 00/0/0/0", HTRANS, rsp_valid, HADDR, HWDATA); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rm_ready_release: got %b expected 1", cmd_ready); end
        tick();
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_no_late_rsp: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_ignore_busy();
        tick();
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0BADF00D;
        issue(1'b0, 3'd2, 32'h0000_0200, 32'h0);
        tick();
        issue(1'b1, 3'd0, 32'h0000_0300, 32'hFFFFFFFF);
        #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ib_ready: got %b expected 0", cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        #1;
        checks++; if (HADDR !== 32'h200 || HWRITE !== 1'b0) begin errors++; $display("FAIL ib_haddr: got a=%h w=%b expected 200/0", HADDR, HWRITE); end
        tick();
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL ib_rsp: got v=%b d=%h expected 1/0badf00d", rsp_valid, rsp_rdata); end
        tick();
        #1;
        checks++; if (HTRANS !== 2'b00 || rsp_valid !== 1'b0) begin errors++; $display("FAIL ib_no_second: got trans=%b v=%b expected 00/0", HTRANS, rsp_valid); end
    endtask

    task automatic test_back_to_back();
        tick();
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h55AA55AA;
        issue(1'b0, 3'd2, 32'h0000_0500, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        issue(1'b1, 3'd0, 32'h0000_0033, 32'h000000A5);
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h55AA55AA || cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_first_rsp: got v=%b d=%h r=%b expected 1/55aa55aa/1", rsp_valid, rsp_rdata, cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        #1;
        checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h33 || HSIZE !== 3'd0 || HWRITE !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_second_addr: got trans=%b a=%h s=%0d w=%b v=%b expected 10/33/0/1/0", HTRANS, HADDR, HSIZE, HWRITE, rsp_valid); end
        tick();
        #1;
        checks++; if (HWDATA !== 32'h000000A5 || HTRANS !== 2'b00) begin errors++; $display("FAIL b2b_second_data: got d=%h trans=%b expected 000000a5/00", HWDATA, HTRANS); end
        tick();
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL b2b_second_rsp: got v=%b e=%b d=%h expected 1/0/0", rsp_valid, rsp_err, rsp_rdata); end
    endtask

    task automatic test_misaligned();
        tick();
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
        issue(1'b0, 3'd2, 32'h0000_1002, 32'h0);
        tick();
        cmd_valid = 1'b0;
        #1;
`ifdef AHB3LITE_MASTER_ALIGN_CHECK_EN
        checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL mis_no_nonseq: got %b expected 00", HTRANS); end
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL mis_err_rsp: got v=%b e=%b r=%b expected 1/1/1", rsp_valid, rsp_err, cmd_ready); end
        tick();
        #1;
        checks++; if (rsp_valid !== 1'b0 || HTRANS !== 2'b00) begin errors++; $display("FAIL mis_after: got v=%b trans=%b expected 0/00", rsp_valid, HTRANS); end
`else
        checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h1002 || HSIZE !== 3'd2) begin errors++; $display("FAIL mis_issued: got trans=%b a=%h s=%0d expected 10/1002/2", HTRANS, HADDR, HSIZE); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mis_no_early_rsp: got %b expected 0", rsp_valid); end
        tick();
        tick();
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL mis_rsp: got v=%b e=%b expected 1/0", rsp_valid, rsp_err); end
`endif
    endtask

    initial begin
        RESET = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 3'd0;
        cmd_addr = 32'h0; cmd_wdata = 32'h0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
        test_reset();
        test_zero_wait_read();
        test_write_wait_states();
        test_error_response();
        test_reset_mid_transfer();
        test_ignore_busy();
        test_back_to_back();
        test_misaligned();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb3lite_simple_master.md
AHB3LITE_SIMPLE_MASTER -- requirements
Module: ahb3lite_simple_master

Interface
REQ-001 SHALL: parameter HPROT_VAL, default 4'b0011, constant value driven on HPROT.
REQ-002 SHALL: CLK  input  1  rising-edge clock for all logic.
REQ-003 SHALL: RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL: cmd_valid  input  1  command request.
REQ-005 SHALL: cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-006 SHALL: cmd_write  input  1  1=write, 0=read.
REQ-007 SHALL: cmd_size  input  3  HSIZE encoding; only 0 (byte), 1 (half), 2 (word) are legal.
REQ-008 SHALL: cmd_addr  input  32  byte address.
REQ-009 SHALL: cmd_wdata  input  32  write data.
REQ-010 SHALL: rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL: rsp_err  output  1  completion was an ERROR; qualified by rsp_valid.
REQ-012 SHALL: rsp_rdata  output  32  read data; qualified by rsp_valid.
REQ-013 SHALL: HADDR  output  32  AHB address.
REQ-014 SHALL: HTRANS  output  2  IDLE (2'b00) or NONSEQ (2'b10) only.
REQ-015 SHALL: HWRITE  output  1  AHB direction.
REQ-016 SHALL: HSIZE  output  3  AHB transfer size.
REQ-017 SHALL: HBURST  output  3  tied to 3'b000 (SINGLE).
REQ-018 SHALL: HPROT  output  4  equals HPROT_VAL.
REQ-019 SHALL: HMASTLOCK  output  1  tied to 0.
REQ-020 SHALL: HWDATA  output  32  write data, valid during the data phase.
REQ-021 SHALL: HREADY  input  1  bus ready from the interconnect.
REQ-022 SHALL: HRESP  input  1  0=OKAY, 1=ERROR.
REQ-023 SHALL: HRDATA  input  32  read data.

Function
REQ-024 SHALL: FSM states are IDLE, ADDR, DATA; one transfer outstanding at most; no pipelining.
REQ-025 SHALL: cmd_ready = (state==IDLE) and not RESET; cmd_valid&cmd_ready latches addr/size/write/wdata and moves to ADDR.
REQ-026 SHALL: ADDR drives HTRANS=NONSEQ with the latched HADDR/HWRITE/HSIZE; if HREADY=1, go to DATA; else hold all outputs stable.
REQ-027 SHALL: DATA drives HTRANS=IDLE and HWDATA=latched wdata (writes); stays in DATA while HREADY=0.
REQ-028 SHALL: DATA with HREADY=1, HRESP=0 -> next cycle rsp_valid=1, rsp_err=0, rsp_rdata=HRDATA (reads) or 0 (writes); state returns to IDLE.
REQ-029 SHALL: in DATA, first ERROR cycle (HRESP=1, HREADY=0) waits; second (HRESP=1, HREADY=1) -> next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0; state returns to IDLE.
REQ-030 SHALL: zero-wait latency: accept at cycle N, NONSEQ at N+1, data phase at N+2, rsp_valid and cmd_ready high at N+3.
REQ-031 SHALL: HADDR/HWRITE/HSIZE hold their last values outside ADDR; rsp_valid never lasts more than one cycle.
REQ-032 SHALL: a cmd_valid pulse not in IDLE is ignored (no buffering).

Reset
REQ-033 SHALL: RESET at any cycle, including mid-transfer, forces next-edge state=IDLE, HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_err=0, rsp_rdata=0; no response is issued for the aborted transfer.
REQ-034 SHALL: cmd_ready is 0 while RESET=1 and 1 in the first cycle after RESET deasserts.

Configuration
REQ-035 SHALL: with AHB3LITE_MASTER_ALIGN_CHECK_EN defined, an accepted command that is misaligned (half with addr[0]=1, word with addr[1:0]!=0) or has cmd_size>2 produces no bus transfer; rsp_valid=1, rsp_err=1 in the next cycle, and the FSM stays in IDLE.
REQ-036 SHALL: without AHB3LITE_MASTER_ALIGN_CHECK_EN, every accepted command is issued unchanged on the bus.

Verification
REQ-037 SHALL: word read at 0x1000 with zero waits and HRDATA=0xDEADBEEF -> NONSEQ at N+1, rsp_valid at N+3 with rsp_rdata=0xDEADBEEF and rsp_err=0.
REQ-038 SHALL: write 0xCAFEF00D to 0x20 with 3 wait states -> HWDATA held stable for 4 data-phase cycles, then a single rsp_valid pulse with rsp_err=0.
REQ-039 SHALL: transfer that receives a two-cycle ERROR -> rsp_err=1, rsp_rdata=0, HTRANS=IDLE throughout the data phase.
REQ-040 SHALL: RESET asserted during a DATA wait state -> next cycle HTRANS=IDLE, no rsp_valid, cmd_ready=1 after release.
REQ-041 SHALL: word read at 0x1002 -> with the macro: no NONSEQ and rsp_err=1 at N+1; without the macro: NONSEQ issued with HADDR=0x1002.
